// File: rtl/fir_coeff_loader_pkg.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader_pkg
// Shared definitions for the FIR coefficient loader and its coefficient bank:
// default word width, tap count, word-counter width and the loader FSM states.
// ---------------------------------------------------------------------------
package fir_coeff_loader_pkg;

  localparam int NB_DEFAULT = 10;
  localparam int N_TAPS     = 11;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// ---------------------------------------------------------------------------
// fir_coeff_bank
// Shadow + active coefficient storage. Words are written one at a time into
// the shadow bank; a commit copies the whole shadow bank into the active bank
// in a single edge so the filter never sees a mixed set.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears both banks)
//   wr_en      : write wr_data into shadow[wr_idx] this cycle
//   wr_idx     : shadow slot being written
//   wr_data    : coefficient word
//   commit     : copy shadow bank to active bank this cycle
//   active     : active bank, element i drives tap b<i>
// ---------------------------------------------------------------------------
module fir_coeff_bank
  import fir_coeff_loader_pkg::*;
#(
  parameter int NB = NB_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [CNT_W-1:0]              wr_idx,
  input  logic [NB-1:0]                 wr_data,
  input  logic                          commit,
  output logic [N_TAPS-1:0][NB-1:0]     active
);

  logic [N_TAPS-1:0][NB-1:0] shadow;

  // Shadow bank: staging area for a load in progress. Stale words left over
  // from an aborted load are simply overwritten by the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[wr_idx] <= wr_data;
    end
  end

  // Active bank: the commit coincides with the write of the last word, so
  // the slot being written on that edge is taken straight from wr_data
  // rather than from the (not yet updated) shadow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (commit) begin
      for (int i = 0; i < N_TAPS; i++) begin
        active[i] <= (wr_en && (wr_idx == CNT_W'(i))) ? wr_data : shadow[i];
      end
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
// Loads 11 FIR coefficients from a serial word stream, commits them
// atomically to b0..b10, and forwards the sample stream only while a
// committed set is active. Samples arriving with no active set are counted.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_start            : begin/restart a coefficient load
//   cfg_data, cfg_valid  : coefficient word stream (b0 first, b10 last)
//   cfg_ready            : high while loading (words accepted)
//   din_in, vin_in       : incoming sample and valid
//   din, vin             : registered sample and valid to the filter
//   b0..b10              : active coefficient bank
//   coeff_ok             : committed set active
//   drop_cnt             : saturating count of discarded samples
// ---------------------------------------------------------------------------
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter int NB     = NB_DEFAULT,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [NB-1:0]     cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [NB-1:0]     din_in,
  input  logic              vin_in,
  output logic [NB-1:0]     din,
  output logic              vin,
  output logic [NB-1:0]     b0,
  output logic [NB-1:0]     b1,
  output logic [NB-1:0]     b2,
  output logic [NB-1:0]     b3,
  output logic [NB-1:0]     b4,
  output logic [NB-1:0]     b5,
  output logic [NB-1:0]     b6,
  output logic [NB-1:0]     b7,
  output logic [NB-1:0]     b8,
  output logic [NB-1:0]     b9,
  output logic [NB-1:0]     b10,
  output logic              coeff_ok,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      accept;
  logic                      commit;
  logic [N_TAPS-1:0][NB-1:0] active;

  // A word is taken only in LOAD and never on a cfg_start cycle; taking the
  // word at slot 10 completes the set and triggers the commit.
  assign accept = (state == LOAD) && cfg_valid && !cfg_start;
  assign commit = accept && (cnt == CNT_W'(N_TAPS - 1));

  // State and word-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and status outputs. cfg_start overrides everything,
  // including a partially completed load.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cfg_ready = 1'b0;
    coeff_ok  = 1'b0;
    if (cfg_start) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        LOAD: begin
          if (commit) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else if (accept) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
    case (state)
      LOAD:    cfg_ready = 1'b1;
      RUN:     coeff_ok  = 1'b1;
      default: ;
    endcase
  end

  // Sample gate: din captures every valid sample, vin only passes in RUN.
  // The sample on the commit edge sees state LOAD and is therefore dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din <= '0;
      vin <= 1'b0;
    end else begin
      if (vin_in) din <= din_in;
      vin <= vin_in && (state == RUN);
    end
  end

  // Dropped-sample counter, cleared by cfg_start and saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (cfg_start) begin
      drop_cnt <= '0;
    end else if (vin_in && (state != RUN) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  fir_coeff_bank #(.NB(NB)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (cnt),
    .wr_data (cfg_data),
    .commit  (commit),
    .active  (active)
  );

  assign b0  = active[0];
  assign b1  = active[1];
  assign b2  = active[2];
  assign b3  = active[3];
  assign b4  = active[4];
  assign b5  = active[5];
  assign b6  = active[6];
  assign b7  = active[7];
  assign b8  = active[8];
  assign b9  = active[9];
  assign b10 = active[10];

endmodule

// File: tb/tb_fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_loader
// Scoreboard bench for fir_coeff_loader. The driver pushes the expected
// output snapshot for every clock and the expected forwarded samples; a
// separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_fir_coeff_loader;

  localparam int NB   = 10;
  localparam int DW   = 8;
  localparam int NT   = 11;
  localparam int DMAX = 255;

  typedef struct packed {
    logic [NT-1:0][NB-1:0] b;
    logic                  coeff_ok;
    logic                  cfg_ready;
    logic                  vin;
    logic [NB-1:0]         din;
    logic [DW-1:0]         drop;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [NB-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [NB-1:0] din_in = '0;
  logic          vin_in = 1'b0;
  logic [NB-1:0] din;
  logic          vin;
  logic [NB-1:0] b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10;
  logic          coeff_ok;
  logic [DW-1:0] drop_cnt;
  logic [NT-1:0][NB-1:0] dut_b;

  int checks = 0;
  int failures = 0;

  snap_t         exp_q[$];
  logic [NB-1:0] sample_q[$];

  // Reference model: a word list for the load in progress, a committed
  // coefficient array and two flags.
  int            m_words[$];
  logic [NT-1:0][NB-1:0] m_active;
  bit            m_loading, m_running;
  logic [NB-1:0] m_din;
  bit            m_vin;
  int            m_drop;

  fir_coeff_loader #(.NB(NB), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .din_in(din_in),
    .vin_in(vin_in), .din(din), .vin(vin),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6),
    .b7(b7), .b8(b8), .b9(b9), .b10(b10),
    .coeff_ok(coeff_ok), .drop_cnt(drop_cnt)
  );

  assign dut_b = {b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic snap_t modelSnap();
    snap_t s;
    s.b = m_active;
    s.coeff_ok = m_running;
    s.cfg_ready = m_loading;
    s.vin = m_vin;
    s.din = m_din;
    s.drop = DW'(m_drop);
    return s;
  endfunction

  task automatic modelReset();
    m_words.delete();
    m_active = '0;
    m_loading = 0;
    m_running = 0;
    m_din = '0;
    m_vin = 0;
    m_drop = 0;
  endtask

  task automatic modelStep(input bit start, input bit valid,
                           input logic [NB-1:0] data, input bit vi,
                           input logic [NB-1:0] di);
    bit was_run;
    was_run = m_running;
    m_vin = vi && was_run;
    if (vi) m_din = di;
    if (m_vin) sample_q.push_back(di);
    if (start) begin
      m_words.delete();
      m_loading = 1;
      m_running = 0;
      m_drop = 0;
    end else begin
      if (vi && !was_run && m_drop < DMAX) m_drop++;
      if (valid && m_loading) begin
        m_words.push_back(int'(data));
        if (m_words.size() == NT) begin
          for (int i = 0; i < NT; i++) m_active[i] = NB'(m_words[i]);
          m_words.delete();
          m_loading = 0;
          m_running = 1;
        end
      end
    end
  endtask

  // Drive one clock of stimulus; the expected post-edge snapshot is queued.
  task automatic applyStimulus(input bit start, input bit valid,
                               input logic [NB-1:0] data, input bit vi,
                               input logic [NB-1:0] di);
    cfg_start = start;
    cfg_valid = valid;
    cfg_data  = data;
    vin_in    = vi;
    din_in    = di;
    modelStep(start, valid, data, vi, di);
    @(posedge clk);
    #1;
    exp_q.push_back(modelSnap());
    cfg_start = 0;
    cfg_valid = 0;
    vin_in    = 0;
  endtask

  task automatic checkAllDirect(input string tag);
    snap_t s;
    s = modelSnap();
    for (int i = 0; i < NT; i++) checkOutput({tag, "_b"}, 32'(dut_b[i]), 32'(s.b[i]));
    checkOutput({tag, "_coeff_ok"}, 32'(coeff_ok), 32'(s.coeff_ok));
    checkOutput({tag, "_cfg_ready"}, 32'(cfg_ready), 32'(s.cfg_ready));
    checkOutput({tag, "_vin"}, 32'(vin), 32'(s.vin));
    checkOutput({tag, "_din"}, 32'(din), 32'(s.din));
    checkOutput({tag, "_drop"}, 32'(drop_cnt), 32'(s.drop));
  endtask

  task automatic loadWords(input int first, input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, NB'(first + i), 0, '0);
  endtask

  // Monitor: compares each queued snapshot and every forwarded sample.
  always @(negedge clk) begin
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      for (int i = 0; i < NT; i++) checkOutput("b_tap", 32'(dut_b[i]), 32'(s.b[i]));
      checkOutput("coeff_ok", 32'(coeff_ok), 32'(s.coeff_ok));
      checkOutput("cfg_ready", 32'(cfg_ready), 32'(s.cfg_ready));
      checkOutput("vin", 32'(vin), 32'(s.vin));
      checkOutput("din", 32'(din), 32'(s.din));
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(s.drop));
    end
    if (rst_n && vin) begin
      if (sample_q.size() == 0) checkOutput("sample_unexpected", 32'(din), 32'hFFFF_FFFF);
      else checkOutput("sample_data", 32'(din), 32'(sample_q.pop_front()));
    end
  end

  initial begin
    bit st, va, vi;
    modelReset();
    #2;
    checkAllDirect("reset");
    @(negedge clk);
    rst_n = 1;

    // Samples with no active set are dropped.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, '0, 1, NB'(i + 7));
    @(negedge clk); #1;
    checkOutput("drop_after_5", 32'(drop_cnt), 32'd5);

    // First load 1..11.
    applyStimulus(1, 0, '0, 0, '0);
    loadWords(1, NT);

    // Sample forwarding and hold.
    applyStimulus(0, 0, '0, 1, 10'h155);
    applyStimulus(0, 0, '0, 0, 10'h0AA);
    applyStimulus(0, 0, '0, 0, '0);

    // Aborted partial load, then full reload 20..30.
    applyStimulus(1, 0, '0, 1, 10'h011);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 10'h3FF, i[0], 10'h0F0);
    applyStimulus(1, 0, '0, 0, '0);
    loadWords(20, NT);

    // Start and valid together: the word is discarded.
    applyStimulus(1, 1, 10'h2AA, 0, '0);
    loadWords(0, NT);
    @(negedge clk); #1;
    checkOutput("b0_after_collision", 32'(b0), 32'd0);
    checkOutput("b10_after_collision", 32'(b10), 32'd10);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 39) == 0);
      va = ($urandom_range(0, 3) != 0);
      vi = st ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus(st, va, NB'($urandom), vi, NB'($urandom));
    end

    // Asynchronous reset in the middle of a load with a set active.
    applyStimulus(1, 0, '0, 0, '0);
    loadWords(100, NT);
    applyStimulus(1, 0, '0, 0, '0);
    loadWords(200, 4);
    @(negedge clk); #1;
    rst_n = 0;
    modelReset();
    #1;
    checkAllDirect("midreset");
    #2;
    rst_n = 1;

    // Saturation of the dropped-sample counter.
    for (int i = 0; i < 300; i++) applyStimulus(0, 0, '0, 1, NB'(i));
    @(negedge clk); #1;
    checkOutput("drop_saturated", 32'(drop_cnt), 32'd255);

    @(negedge clk); #1;
    checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("sample_q_drained", 32'(sample_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
